lite16_issue: RTL and testbench



---
 rtl/lite16_pkg.sv | 33 +++
 rtl/lite16_regfile.sv | 48 ++++
 rtl/lite16_issue.sv | 142 ++++++++++++++
 tb/tb_lite16_issue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lite16_pkg.sv
// lite16_pkg: shared definitions for the LITE-16 execute sequencer.
//   - instruction field positions
//   - OP_CMP, the codeop that updates cmp_flag instead of a register
//   - state_t, the sequencer FSM encoding
//   - sext6(), imm6 to 16-bit sign extension
package lite16_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RI_BIT  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

endpackage

// File: rtl/lite16_regfile.sv
// lite16_regfile: 8x16 register file.
//   clk, rst_n            clock, asynchronous active-low reset (clears all entries)
//   ra_idx/ra_data        read port A (combinational)
//   rb_idx/rb_data        read port B (combinational)
//   rd_idx/rd_data        read port for the destination's old value (combinational)
//   dbg_idx/dbg_data      debug read port (combinational)
//   we, wa, wd            synchronous write port
// R0 always reads zero and ignores writes.
import lite16_pkg::*;

module lite16_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ra_idx,
    input  logic [2:0]  rb_idx,
    input  logic [2:0]  rd_idx,
    input  logic [2:0]  dbg_idx,
    output logic [15:0] ra_data,
    output logic [15:0] rb_data,
    output logic [15:0] rd_data,
    output logic [15:0] dbg_data,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd
);

    logic [15:0] mem [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (we && (wa != 3'd0)) begin
            mem[wa] <= wd;
        end
    end

    // The explicit zero on index 0 keeps R0 hardwired even though mem[0]
    // is never written.
    always_comb begin
        ra_data  = (ra_idx  == 3'd0) ? 16'h0000 : mem[ra_idx];
        rb_data  = (rb_idx  == 3'd0) ? 16'h0000 : mem[rb_idx];
        rd_data  = (rd_idx  == 3'd0) ? 16'h0000 : mem[rd_idx];
        dbg_data = (dbg_idx == 3'd0) ? 16'h0000 : mem[dbg_idx];
    end

endmodule

// File: rtl/lite16_issue.sv
// lite16_issue: single-issue execute sequencer sitting in front of the ALU.
//   clk, rst_n      clock, asynchronous active-low reset
//   instr           16-bit instruction, sampled on accept
//   instr_valid     upstream offers instr
//   instr_ready     registered; high only while IDLE
//   alu_codeop/a/b/rd/ri   registered operands driven to the ALU
//   alu_r, alu_cmp  ALU combinational result and compare
//   cmp_flag        registered compare flag (updated by OP_CMP)
//   retire          one-cycle pulse after the write-back edge
//   dbg_addr/dbg_data  combinational register-file peek
//   dbg_state       current FSM state
//
// Handshake: an instruction is accepted on a rising edge where
// instr_valid && instr_ready; instr_ready only rises in IDLE, so valid is
// ignored in READ/EXEC/WB. One instruction retires every four cycles:
// accept (edge 0), operands latched (edge 1), ALU sampled (edge 2),
// write-back and retire (edge 3).
import lite16_pkg::*;

module lite16_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  alu_codeop,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] alu_rd,
    output logic        alu_ri,
    input  logic [15:0] alu_r,
    input  logic        alu_cmp,
    output logic        cmp_flag,
    output logic        retire,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output state_t      dbg_state
);

    state_t      state, state_next;
    logic [15:0] instr_q;
    logic [15:0] a_q, b_q, rd_q, r_q;
    logic [2:0]  op_q;
    logic        ri_q, c_q;
    logic [15:0] ra_data, rb_data, rd_data;
    logic        accept;
    logic        we;

    assign accept = instr_valid && instr_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;

    // ---------------- register file ----------------
    // Write only from WB, and never for a compare.
    assign we = (state == WB) && (instr_q[OP_MSB:OP_LSB] != OP_CMP);

    lite16_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_idx   (instr_q[RA_MSB:RA_LSB]),
        .rb_idx   (instr_q[RB_MSB:RB_LSB]),
        .rd_idx   (instr_q[RD_MSB:RD_LSB]),
        .dbg_idx  (dbg_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .rd_data  (rd_data),
        .dbg_data (dbg_data),
        .we       (we),
        .wa       (instr_q[RD_MSB:RD_LSB]),
        .wd       (r_q)
    );

    // ---------------- datapath ----------------
    // codeop/ri are copied into their own registers at READ together with
    // the operands, so every alu_* output changes on the same edge and
    // never mid-instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= 16'h0000;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            rd_q        <= 16'h0000;
            r_q         <= 16'h0000;
            op_q        <= 3'd0;
            ri_q        <= 1'b0;
            c_q         <= 1'b0;
            cmp_flag    <= 1'b0;
            retire      <= 1'b0;
            instr_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) instr_q <= instr;
                end
                READ: begin
                    a_q  <= ra_data;
                    b_q  <= instr_q[RI_BIT] ? sext6(instr_q[IMM_MSB:IMM_LSB]) : rb_data;
                    rd_q <= rd_data;
                    op_q <= instr_q[OP_MSB:OP_LSB];
                    ri_q <= instr_q[RI_BIT];
                end
                EXEC: begin
                    r_q <= alu_r;
                    c_q <= alu_cmp;
                end
                WB: begin
                    if (instr_q[OP_MSB:OP_LSB] == OP_CMP) cmp_flag <= c_q;
                end
                default: ;
            endcase
            retire      <= (state == WB);
            instr_ready <= (state_next == IDLE);
        end
    end

    assign alu_codeop = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_rd     = rd_q;
    assign alu_ri     = ri_q;

endmodule

// File: tb/tb_lite16_issue.sv
// Directed bench for lite16_issue. The ALU is stubbed as r=a+b, cmp=(a==rd).
import lite16_pkg::*;

module tb_lite16_issue;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  alu_codeop;
    logic [15:0] alu_a, alu_b, alu_rd;
    logic        alu_ri;
    logic [15:0] alu_r;
    logic        alu_cmp;
    logic        cmp_flag;
    logic        retire;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    state_t      dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    lite16_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_codeop  (alu_codeop),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_rd      (alu_rd),
        .alu_ri      (alu_ri),
        .alu_r       (alu_r),
        .alu_cmp     (alu_cmp),
        .cmp_flag    (cmp_flag),
        .retire      (retire),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .dbg_state   (dbg_state)
    );

    // ALU stub
    assign alu_r   = alu_a + alu_b;
    assign alu_cmp = (alu_a == alu_rd);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // ---------------- driver ----------------
    // Starts in IDLE with instr_ready high, one time unit after an edge.
    // Returns one time unit after the write-back edge.
    task automatic issue(input string tag, input logic [15:0] ins,
                         input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] erd);
        logic [15:0] w;
        w = ins;
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;                       // edge 0
        instr_valid = 1'b0;
        instr       = 16'hFFFF;                   // must not be sampled again
        check({tag, ".ready0"},  {15'd0, instr_ready}, 16'd0);
        check({tag, ".st_read"}, {14'd0, dbg_state}, {14'd0, READ});
        check({tag, ".ret0"},    {15'd0, retire}, 16'd0);
        @(posedge clk); #1;                       // edge 1
        check({tag, ".a"},  alu_a,  ea);
        check({tag, ".b"},  alu_b,  eb);
        check({tag, ".rd"}, alu_rd, erd);
        check({tag, ".op"}, {13'd0, alu_codeop}, {13'd0, w[15:13]});
        check({tag, ".ri"}, {15'd0, alu_ri},     {15'd0, w[12]});
        @(posedge clk); #1;                       // edge 2
        check({tag, ".st_wb"},   {14'd0, dbg_state}, {14'd0, WB});
        check({tag, ".a_hold"},  alu_a, ea);
        @(posedge clk); #1;                       // edge 3
        check({tag, ".ret1"},    {15'd0, retire}, 16'd1);
        check({tag, ".ready1"},  {15'd0, instr_ready}, 16'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic rb;
        rst_n       = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        dbg_addr    = 3'd0;

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready",  {15'd0, instr_ready}, 16'd0);
        check("rst.cmp",    {15'd0, cmp_flag}, 16'd0);
        check("rst.retire", {15'd0, retire}, 16'd0);
        check("rst.alu_a",  alu_a, 16'd0);
        check("rst.alu_b",  alu_b, 16'd0);

        // Release: ready rises one edge later
        rst_n = 1'b1;
        #1;
        check("rel.ready_pre", {15'd0, instr_ready}, 16'd0);
        @(posedge clk); #1;
        check("rel.ready_post", {15'd0, instr_ready}, 16'd1);
        for (int i = 0; i < 8; i++) begin
            check_reg("rel.reg", 3'(i), 16'h0000);
        end
        @(posedge clk); #1;

        // Immediate write: op0 ri1 rd1 ra1(=0) imm6=7 -> R1=7
        issue("imm", 16'h1247, 16'h0000, 16'h0007, 16'h0000);
        check_reg("imm.r1", 3'd1, 16'h0007);
        @(posedge clk); #1;
        check("imm.ret_once", {15'd0, retire}, 16'd0);

        // Sign extension: op0 ri1 rd2 ra1 imm6=3F -> 7 + FFFF = 6
        issue("sext", 16'h147F, 16'h0007, 16'hFFFF, 16'h0000);
        check_reg("sext.r2", 3'd2, 16'h0006);

        // Register mode: op0 ri0 rd3 ra1 rb2 -> 7 + 6 = 13
        issue("reg", 16'h0650, 16'h0007, 16'h0006, 16'h0000);
        check_reg("reg.r3", 3'd3, 16'h000D);

        // Equal compare: op7 rd3 ra3 rb1 -> a=13, rd=13: flag set, R3 kept
        issue("cmpeq", 16'hE6C8, 16'h000D, 16'h0007, 16'h000D);
        check("cmpeq.flag", {15'd0, cmp_flag}, 16'd1);
        check_reg("cmpeq.r3", 3'd3, 16'h000D);

        // Unequal compare: op7 rd2 ra1 rb0 -> a=7, rd=6: flag cleared, R2 kept
        issue("cmpne", 16'hE440, 16'h0007, 16'h0000, 16'h0006);
        check("cmpne.flag", {15'd0, cmp_flag}, 16'd0);
        check_reg("cmpne.r2", 3'd2, 16'h0006);

        // Write to R0: op0 ri1 rd0 ra1 imm6=5 -> discarded
        issue("r0", 16'h1045, 16'h0007, 16'h0005, 16'h0000);
        check_reg("r0.r0", 3'd0, 16'h0000);

        // rd==ra==rb: op0 ri0 rd1 ra1 rb1 -> old 7 + 7 = 14
        issue("self", 16'h0248, 16'h0007, 16'h0007, 16'h0007);
        check_reg("self.r1", 3'd1, 16'h000E);

        // Valid held high with a dependent R4 += 1 chain: accepts at
        // edges 0, 4, 8 of a 12-edge window, and R4 ends at 3.
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd4);
        exp_q.push_back(16'd8);
        instr       = 16'h1901;
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rb = instr_ready;
            @(posedge clk); #1;
            if (rb) begin
                if (exp_q.size() > 0) begin
                    check("b2b.accept_edge", 16'(i), exp_q.pop_front());
                end else begin
                    check("b2b.extra_accept", 16'(i), 16'hFFFF);
                end
            end
        end
        instr_valid = 1'b0;
        check("b2b.missing", 16'(exp_q.size()), 16'd0);
        check_reg("b2b.r4", 3'd4, 16'h0003);

        // Set cmp_flag, then abort the next instruction in EXEC
        issue("precmp", 16'hE6C8, 16'h000D, 16'h000E, 16'h000D);
        check("precmp.flag", {15'd0, cmp_flag}, 16'd1);
        instr       = 16'h1A43;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("abort.in_exec", {14'd0, dbg_state}, {14'd0, EXEC});
        rst_n = 1'b0;
        #1;
        check("abort.ready",  {15'd0, instr_ready}, 16'd0);
        check("abort.cmp",    {15'd0, cmp_flag}, 16'd0);
        check("abort.retire", {15'd0, retire}, 16'd0);
        check("abort.a",      alu_a, 16'd0);
        check("abort.b",      alu_b, 16'd0);
        check("abort.rd",     alu_rd, 16'd0);
        check("abort.op",     {13'd0, alu_codeop}, 16'd0);
        check("abort.ri",     {15'd0, alu_ri}, 16'd0);
        check_reg("abort.r5", 3'd5, 16'h0000);
        check_reg("abort.r1", 3'd1, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post.ready", {15'd0, instr_ready}, 16'd1);
        check("post.state", {14'd0, dbg_state}, {14'd0, IDLE});

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
